// File: rtl/wb_dcache_nway_datapath.sv
// N-way set-associative write-back data cache datapath: tag/valid/dirty/data arrays,
// tag compare, tree-PLRU victim selection and the set/way flush walk.
module wb_dcache_nway_datapath #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 4,
    parameter int NUM_SETS   = 128,
    parameter int NUM_WAYS   = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             cache_rd_i,
    input  logic                             cache_wr_i,
    input  logic                             cache_line_wr_i,
    input  logic                             cache_line_clean_i,
    input  logic                             cache_wrb_req_i,
    input  logic                             dcache_flush_i,
    input  logic                             flush_step_i,
    input  logic [ADDR_WIDTH-1:0]            lsummu2dcache_addr_i,
    input  logic [DATA_WIDTH-1:0]            lsummu2dcache_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]          sel_byte_i,
    input  logic [LINE_WORDS*DATA_WIDTH-1:0] mem2dcache_data_i,
    output logic                             cache_hit_o,
    output logic                             cache_evict_req_o,
    output logic                             flush_done_o,
    output logic [DATA_WIDTH-1:0]            dcache2lsummu_data_o,
    output logic [LINE_WORDS*DATA_WIDTH-1:0] dcache2mem_data_o,
    output logic [ADDR_WIDTH-1:0]            dcache2mem_addr_o
);

    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int LINE_BITS = LINE_WORDS * DATA_WIDTH;
    localparam int BYTE_OFF  = $clog2(BYTES);
    localparam int WORD_BITS = $clog2(LINE_WORDS);
    localparam int OFF_BITS  = BYTE_OFF + WORD_BITS;
    localparam int IDX_BITS  = $clog2(NUM_SETS);
    localparam int TAG_BITS  = ADDR_WIDTH - IDX_BITS - OFF_BITS;
    localparam int WAY_BITS  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int LEVELS    = $clog2(NUM_WAYS);

    localparam logic [WAY_BITS-1:0] LAST_WAY = WAY_BITS'(NUM_WAYS - 1);
    localparam logic [IDX_BITS-1:0] LAST_SET = IDX_BITS'(NUM_SETS - 1);

    logic [TAG_BITS-1:0]  addr_tag;
    logic [IDX_BITS-1:0]  addr_idx;
    logic [WORD_BITS-1:0] addr_word;
    int                   word_base;

    assign addr_tag  = lsummu2dcache_addr_i[ADDR_WIDTH-1 -: TAG_BITS];
    assign addr_idx  = lsummu2dcache_addr_i[OFF_BITS +: IDX_BITS];
    assign addr_word = lsummu2dcache_addr_i[BYTE_OFF +: WORD_BITS];
    assign word_base = int'(addr_word) * DATA_WIDTH;

    if (BYTE_OFF > 0) begin : g_byte_bits
        logic unused_byte_bits;
        assign unused_byte_bits = ^lsummu2dcache_addr_i[BYTE_OFF-1:0];
    end

    logic [TAG_BITS-1:0]  tag_mem  [NUM_SETS][NUM_WAYS];
    logic [LINE_BITS-1:0] data_mem [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]  valid_q  [NUM_SETS];
    logic [NUM_WAYS-1:0]  dirty_q  [NUM_SETS];

    logic                 hit;
    logic [WAY_BITS-1:0]  hit_way;
    logic [WAY_BITS-1:0]  victim;
    logic [WAY_BITS-1:0]  plru_victim;
    logic [WAY_BITS-1:0]  victim_q;
    logic [IDX_BITS-1:0]  sel_set;
    logic [WAY_BITS-1:0]  sel_way;
    logic [IDX_BITS-1:0]  flush_set_q;
    logic [WAY_BITS-1:0]  flush_way_q;
    logic                 flush_done_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [LINE_BITS-1:0] hit_line;
    logic [LINE_BITS-1:0] merged_line;
    logic [DATA_WIDTH-1:0] hit_word;
    logic                 wr_upd;
    logic                 line_upd;
    logic                 plru_touch;
    logic [WAY_BITS-1:0]  plru_way;

    // Lowest matching valid way wins if more than one ever matched.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[addr_idx][w] && (tag_mem[addr_idx][w] == addr_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
        end
    end

    always_comb begin
        victim = plru_victim;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[addr_idx][w]) begin
                victim = WAY_BITS'(w);
            end
        end
    end

    always_comb begin
        sel_set = addr_idx;
        sel_way = victim_q;
        if (dcache_flush_i) begin
            sel_set = flush_set_q;
            sel_way = flush_way_q;
        end else if (hit) begin
            sel_way = hit_way;
        end
    end

    // Only one array update per cycle: clean beats a store hit, which beats a refill.
    assign wr_upd     = cache_wr_i && hit && !cache_line_clean_i;
    assign line_upd   = cache_line_wr_i && !cache_line_clean_i && !wr_upd;
    assign plru_touch = (cache_rd_i && hit) || wr_upd || line_upd;
    assign plru_way   = ((cache_rd_i && hit) || wr_upd) ? hit_way : victim_q;

    always_comb begin
        hit_line    = data_mem[addr_idx][hit_way];
        hit_word    = hit_line[word_base +: DATA_WIDTH];
        merged_line = hit_line;
        for (int b = 0; b < BYTES; b++) begin
            if (sel_byte_i[b]) begin
                merged_line[word_base + b*8 +: 8] = lsummu2dcache_wdata_i[b*8 +: 8];
            end
        end
    end

    if (NUM_WAYS > 1) begin : g_plru
        localparam int PLRU_BITS = NUM_WAYS - 1;

        logic [PLRU_BITS-1:0] plru_q [NUM_SETS];
        logic [PLRU_BITS-1:0] plru_cur;
        logic [PLRU_BITS-1:0] plru_next;
        logic                 node_bit;
        logic                 dir;
        int                   vnode;
        int                   unode;

        // Heap-ordered tree: node n has children 2n+1 (lower half) and 2n+2 (upper half).
        always_comb begin
            plru_cur  = plru_q[addr_idx];
            plru_next = plru_cur;
            node_bit  = 1'b0;
            dir       = 1'b0;
            vnode     = 0;
            unode     = 0;
            for (int lvl = 0; lvl < LEVELS; lvl++) begin
                node_bit = 1'b0;
                for (int n = 0; n < PLRU_BITS; n++) begin
                    if (n == vnode) begin
                        node_bit = plru_cur[n];
                    end
                end
                vnode = 2*vnode + 1 + int'(node_bit);

                dir = plru_way[WAY_BITS-1-lvl];
                for (int n = 0; n < PLRU_BITS; n++) begin
                    if (n == unode) begin
                        plru_next[n] = ~dir;
                    end
                end
                unode = 2*unode + 1 + int'(dir);
            end
        end

        assign plru_victim = WAY_BITS'(vnode - PLRU_BITS);

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int s = 0; s < NUM_SETS; s++) begin
                    plru_q[s] <= '0;
                end
            end else if (plru_touch) begin
                plru_q[addr_idx] <= plru_next;
            end
        end
    end else begin : g_no_plru
        logic unused_plru;
        assign unused_plru = plru_touch ^ (^plru_way);
        assign plru_victim = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else if (cache_line_clean_i) begin
            dirty_q[sel_set][sel_way] <= 1'b0;
        end else if (wr_upd) begin
            dirty_q[addr_idx][hit_way] <= 1'b1;
        end else if (line_upd) begin
            valid_q[addr_idx][victim_q] <= 1'b1;
            dirty_q[addr_idx][victim_q] <= 1'b0;
        end
    end

    // Tag and data storage carry no reset so they can map onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (wr_upd) begin
            data_mem[addr_idx][hit_way] <= merged_line;
        end else if (line_upd) begin
            tag_mem[addr_idx][victim_q]  <= addr_tag;
            data_mem[addr_idx][victim_q] <= mem2dcache_data_i;
        end
    end

    // The victim is latched on a miss so the writeback and the refill target the same way.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            victim_q <= '0;
            data_q   <= '0;
        end else begin
            if ((cache_rd_i || cache_wr_i) && !hit) begin
                victim_q <= victim;
            end
            if (cache_rd_i && hit) begin
                data_q <= hit_word;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flush_set_q  <= '0;
            flush_way_q  <= '0;
            flush_done_q <= 1'b0;
        end else if (!dcache_flush_i) begin
            flush_set_q  <= '0;
            flush_way_q  <= '0;
            flush_done_q <= 1'b0;
        end else if (flush_step_i && !flush_done_q) begin
            if (flush_way_q == LAST_WAY) begin
                flush_way_q <= '0;
                if (flush_set_q == LAST_SET) begin
                    flush_set_q  <= '0;
                    flush_done_q <= 1'b1;
                end else begin
                    flush_set_q <= flush_set_q + IDX_BITS'(1);
                end
            end else begin
                flush_way_q <= flush_way_q + WAY_BITS'(1);
            end
        end
    end

    assign cache_hit_o          = hit;
    assign cache_evict_req_o    = valid_q[sel_set][sel_way] & dirty_q[sel_set][sel_way];
    assign flush_done_o         = flush_done_q;
    assign dcache2lsummu_data_o = data_q;
    assign dcache2mem_data_o    = data_mem[sel_set][sel_way];
    assign dcache2mem_addr_o    = cache_wrb_req_i
                                ? {tag_mem[sel_set][sel_way], sel_set, {OFF_BITS{1'b0}}}
                                : {addr_tag, addr_idx, {OFF_BITS{1'b0}}};

endmodule

// File: tb/tb_wb_dcache_nway_datapath.sv
// Directed bench for wb_dcache_nway_datapath, built as 2 sets x 2 ways so that
// 0x0000/0x1000/0x2000 share set 0 and the flush walk covers four lines.
module tb_wb_dcache_nway_datapath;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int LINE_WORDS = 4;
    localparam int NUM_SETS   = 2;
    localparam int NUM_WAYS   = 2;
    localparam int LINE_BITS  = LINE_WORDS * DATA_WIDTH;

    localparam logic [LINE_BITS-1:0] LINE_A = 128'h44444444_33333333_22222222_11111111;
    localparam logic [LINE_BITS-1:0] LINE_B = 128'hBBBB0003_BBBB0002_BBBB0001_BBBB0000;
    localparam logic [LINE_BITS-1:0] LINE_C = 128'hCCCC0003_CCCC0002_CCCC0001_CCCC0000;
    localparam logic [LINE_BITS-1:0] LINE_D = 128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000;
    localparam logic [LINE_BITS-1:0] LINE_E = 128'hDEAD0003_DEAD0002_DEAD0001_55667788;
    localparam logic [LINE_BITS-1:0] LINE_E_MERGED = 128'hDEAD0003_DEAD0002_DEAD0001_5566CC88;
    localparam logic [LINE_BITS-1:0] LINE_F = 128'hF0F00003_F0F00002_F0F00001_F0F00000;

    logic                    clk_i;
    logic                    rst_ni;
    logic                    cache_rd_i;
    logic                    cache_wr_i;
    logic                    cache_line_wr_i;
    logic                    cache_line_clean_i;
    logic                    cache_wrb_req_i;
    logic                    dcache_flush_i;
    logic                    flush_step_i;
    logic [ADDR_WIDTH-1:0]   lsummu2dcache_addr_i;
    logic [DATA_WIDTH-1:0]   lsummu2dcache_wdata_i;
    logic [DATA_WIDTH/8-1:0] sel_byte_i;
    logic [LINE_BITS-1:0]    mem2dcache_data_i;
    logic                    cache_hit_o;
    logic                    cache_evict_req_o;
    logic                    flush_done_o;
    logic [DATA_WIDTH-1:0]   dcache2lsummu_data_o;
    logic [LINE_BITS-1:0]    dcache2mem_data_o;
    logic [ADDR_WIDTH-1:0]   dcache2mem_addr_o;

    int checks = 0;
    int errors = 0;

    wb_dcache_nway_datapath #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .LINE_WORDS(LINE_WORDS),
        .NUM_SETS  (NUM_SETS),
        .NUM_WAYS  (NUM_WAYS)
    ) dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .cache_rd_i           (cache_rd_i),
        .cache_wr_i           (cache_wr_i),
        .cache_line_wr_i      (cache_line_wr_i),
        .cache_line_clean_i   (cache_line_clean_i),
        .cache_wrb_req_i      (cache_wrb_req_i),
        .dcache_flush_i       (dcache_flush_i),
        .flush_step_i         (flush_step_i),
        .lsummu2dcache_addr_i (lsummu2dcache_addr_i),
        .lsummu2dcache_wdata_i(lsummu2dcache_wdata_i),
        .sel_byte_i           (sel_byte_i),
        .mem2dcache_data_i    (mem2dcache_data_i),
        .cache_hit_o          (cache_hit_o),
        .cache_evict_req_o    (cache_evict_req_o),
        .flush_done_o         (flush_done_o),
        .dcache2lsummu_data_o (dcache2lsummu_data_o),
        .dcache2mem_data_o    (dcache2mem_data_o),
        .dcache2mem_addr_o    (dcache2mem_addr_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic apply_stimulus(input logic rd, input logic wr, input logic lw,
                                  input logic clean, input logic wrb,
                                  input logic [ADDR_WIDTH-1:0] addr,
                                  input logic [DATA_WIDTH-1:0] wdata,
                                  input logic [DATA_WIDTH/8-1:0] sel);
        cache_rd_i            = rd;
        cache_wr_i            = wr;
        cache_line_wr_i       = lw;
        cache_line_clean_i    = clean;
        cache_wrb_req_i       = wrb;
        lsummu2dcache_addr_i  = addr;
        lsummu2dcache_wdata_i = wdata;
        sel_byte_i            = sel;
        #1;
    endtask

    task automatic check_output(input string name, input logic [LINE_BITS-1:0] observed,
                                input logic [LINE_BITS-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", name, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_rd(input logic [ADDR_WIDTH-1:0] addr);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, addr, '0, '0);
    endtask

    task automatic do_refill(input logic [ADDR_WIDTH-1:0] addr, input logic [LINE_BITS-1:0] line);
        mem2dcache_data_i = line;
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, addr, '0, '0);
        tick();
    endtask

    task automatic do_idle(input logic [ADDR_WIDTH-1:0] addr);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, addr, '0, '0);
    endtask

    initial begin
        rst_ni            = 1'b0;
        dcache_flush_i    = 1'b0;
        flush_step_i      = 1'b0;
        mem2dcache_data_i = '0;
        do_idle(32'h0);
        #1;
        check_output("rst_hit", cache_hit_o, 1'b0);
        check_output("rst_evict", cache_evict_req_o, 1'b0);
        check_output("rst_flush_done", flush_done_o, 1'b0);
        check_output("rst_data", dcache2lsummu_data_o, 32'h0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // First miss, refill into way 0, then a hit with one-cycle load latency.
        do_rd(32'h100);
        check_output("miss_hit", cache_hit_o, 1'b0);
        check_output("miss_evict", cache_evict_req_o, 1'b0);
        check_output("miss_memaddr", dcache2mem_addr_o, 32'h100);
        tick();
        do_refill(32'h100, LINE_A);
        do_rd(32'h104);
        check_output("hit_104", cache_hit_o, 1'b1);
        check_output("hit_evict", cache_evict_req_o, 1'b0);
        tick();
        check_output("load_word1", dcache2lsummu_data_o, 32'h22222222);

        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        do_rd(32'h104);
        check_output("reset_invalidates", cache_hit_o, 1'b0);
        check_output("reset_data", dcache2lsummu_data_o, 32'h0);
        tick();

        // Two lines in set 0, touch 0x0000 so PLRU points at way 1 for the next miss.
        do_rd(32'h0000);
        tick();
        do_refill(32'h0000, LINE_B);
        do_rd(32'h1000);
        tick();
        do_refill(32'h1000, LINE_C);
        do_rd(32'h0000);
        check_output("touch_0000", cache_hit_o, 1'b1);
        tick();
        do_rd(32'h2000);
        check_output("miss_2000", cache_hit_o, 1'b0);
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2000, '0, '0);
        check_output("plru_victim_addr", dcache2mem_addr_o, 32'h1000);
        check_output("plru_victim_data", dcache2mem_data_o, LINE_C);
        check_output("clean_victim_evict", cache_evict_req_o, 1'b0);
        tick();
        do_refill(32'h2000, LINE_D);
        do_rd(32'h1000);
        check_output("replaced_1000", cache_hit_o, 1'b0);
        tick();
        do_rd(32'h0000);
        check_output("kept_0000", cache_hit_o, 1'b1);
        tick();
        check_output("load_0000", dcache2lsummu_data_o, 32'hBBBB0000);
        do_rd(32'h2000);
        check_output("hit_2000", cache_hit_o, 1'b1);
        tick();
        check_output("load_2000", dcache2lsummu_data_o, 32'hDDDD0000);

        // Byte-merge store in set 1, then force that dirty line out as the victim.
        do_rd(32'h10);
        tick();
        do_refill(32'h10, LINE_E);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'hAABBCCDD, 4'b0010);
        check_output("store_hit", cache_hit_o, 1'b1);
        tick();
        do_rd(32'h10);
        check_output("store_dirty", cache_evict_req_o, 1'b1);
        tick();
        check_output("store_merge", dcache2lsummu_data_o, 32'h5566CC88);
        do_rd(32'h30);
        check_output("miss_30", cache_hit_o, 1'b0);
        tick();
        do_refill(32'h30, LINE_F);
        do_rd(32'h50);
        check_output("miss_50", cache_hit_o, 1'b0);
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h50, '0, '0);
        check_output("dirty_victim_evict", cache_evict_req_o, 1'b1);
        check_output("wrb_addr_old_tag", dcache2mem_addr_o, 32'h10);
        check_output("wrb_data", dcache2mem_data_o, LINE_E_MERGED);
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h50, '0, '0);
        tick();
        do_idle(32'h50);
        check_output("clean_clears_dirty", cache_evict_req_o, 1'b0);

        // Clean and store on the same line in one cycle: only the clean takes effect.
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h14, 32'h12345678, 4'b1111);
        tick();
        do_rd(32'h14);
        check_output("redirty", cache_evict_req_o, 1'b1);
        tick();
        check_output("full_store", dcache2lsummu_data_o, 32'h12345678);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h14, 32'hFFFFFFFF, 4'b1111);
        tick();
        do_rd(32'h14);
        check_output("clean_beats_wr_dirty", cache_evict_req_o, 1'b0);
        tick();
        check_output("clean_beats_wr_data", dcache2lsummu_data_o, 32'h12345678);

        // Flush walk over four lines with only set 1 / way 1 dirty.
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h30, 32'h000000EE, 4'b0001);
        tick();
        dcache_flush_i = 1'b1;
        do_idle(32'h0);
        check_output("flush_pos0_evict", cache_evict_req_o, 1'b0);
        check_output("flush_pos0_done", flush_done_o, 1'b0);
        flush_step_i = 1'b1;
        tick();
        check_output("flush_pos1_evict", cache_evict_req_o, 1'b0);
        tick();
        check_output("flush_pos2_evict", cache_evict_req_o, 1'b0);
        tick();
        flush_step_i = 1'b0;
        check_output("flush_pos3_evict", cache_evict_req_o, 1'b1);
        check_output("flush_pos3_done", flush_done_o, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, '0, '0);
        check_output("flush_wrb_addr", dcache2mem_addr_o, 32'h30);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, '0, '0);
        tick();
        do_idle(32'h0);
        check_output("flush_cleaned", cache_evict_req_o, 1'b0);
        flush_step_i = 1'b1;
        tick();
        check_output("flush_done_4", flush_done_o, 1'b1);
        tick();
        check_output("flush_done_sticky", flush_done_o, 1'b1);
        flush_step_i   = 1'b0;
        dcache_flush_i = 1'b0;
        tick();
        check_output("flush_exit_done", flush_done_o, 1'b0);

        // Asynchronous reset in the middle of a refill cycle.
        mem2dcache_data_i = LINE_A;
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h2000, '0, '0);
        #2;
        rst_ni = 1'b0;
        #1;
        check_output("async_rst_hit", cache_hit_o, 1'b0);
        check_output("async_rst_evict", cache_evict_req_o, 1'b0);
        check_output("async_rst_done", flush_done_o, 1'b0);
        check_output("async_rst_data", dcache2lsummu_data_o, 32'h0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        do_rd(32'h0000);
        check_output("post_rst_0000", cache_hit_o, 1'b0);
        do_rd(32'h10);
        check_output("post_rst_10", cache_hit_o, 1'b0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
